// File: rtl/sdm_pkg.sv
// Shared definitions for the SDM event monitor: FSM encoding, default widths
// and the per-cycle control bundle passed from the FSM to the datapath.
package sdm_pkg;

    localparam int SDM_CNT_W = 16;
    localparam int SDM_WIN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10
    } sdm_state_e;

    // Datapath commands decided by the FSM for the current cycle.
    typedef struct packed {
        logic tot_inc;    // count one event into total_count
        logic win_inc;    // count one event into win_count
        logic win_clr;    // restart the window count
        logic tmr_inc;    // advance the window timer
        logic tmr_clr;    // restart the window timer
        logic alarm_set;  // threshold reached this cycle
    } sdm_ctrl_t;

endpackage

// File: rtl/sdm_sat_counter.sv
// Saturating up-counter: sticks at all-ones, synchronous clear beats increment.
module sdm_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register; never wraps past all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                    count <= '0;
        else if (clr)                    count <= '0;
        else if (inc && (count != '1))   count <= count + W'(1);
    end

endmodule

// File: rtl/sdm_event_monitor.sv
// Event monitor for a sequence detector: counts detections in total and per
// window, raises a sticky alarm when a window reaches the threshold.
module sdm_event_monitor
    import sdm_pkg::*;
#(
    parameter int CNT_W = SDM_CNT_W,
    parameter int WIN_W = SDM_WIN_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             det_in,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic [CNT_W-1:0] total_count,
    output logic [CNT_W-1:0] win_count,
    output logic             alarm,
    output logic             alarm_pulse,
    output logic             overflow,
    output logic             io_oeb
);

    sdm_state_e       state, state_nxt;
    sdm_ctrl_t        ctrl;
    logic [WIN_W-1:0] timer;
    logic [CNT_W:0]   win_sum;
    logic             thr_hit;
    logic             last_cycle;

    // Extra bit so a saturated win_count plus an event still compares correctly.
    assign win_sum    = {1'b0, win_count} + {{CNT_W{1'b0}}, det_in};
    assign thr_hit    = (threshold != '0) && (win_sum >= {1'b0, threshold});
    assign last_cycle = (window_len != '0) && (timer == window_len - WIN_W'(1));
    assign io_oeb     = 1'b0;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and datapath commands; clear overrides everything and drops
    // any event seen in the same cycle.
    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        if (clear) begin
            ctrl.win_clr = 1'b1;
            ctrl.tmr_clr = 1'b1;
            state_nxt    = enable ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) state_nxt = RUN;
                end
                RUN: begin
                    if (!enable) begin
                        ctrl.win_clr = 1'b1;
                        ctrl.tmr_clr = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        ctrl.tot_inc = det_in;
                        if (thr_hit) begin
                            // Alarm wins over window expiry: the last-cycle
                            // event stays in the frozen window count.
                            ctrl.alarm_set = 1'b1;
                            ctrl.win_inc   = det_in;
                            state_nxt      = ALARM;
                        end else if (last_cycle) begin
                            ctrl.win_clr = 1'b1;
                            ctrl.tmr_clr = 1'b1;
                        end else begin
                            ctrl.win_inc = det_in;
                            ctrl.tmr_inc = 1'b1;
                        end
                    end
                end
                ALARM: begin
                    ctrl.tot_inc = det_in & enable;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Window timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          timer <= '0;
        else if (ctrl.tmr_clr) timer <= '0;
        else if (ctrl.tmr_inc) timer <= timer + WIN_W'(1);
    end

    // Sticky alarm plus its one-cycle strobe (only RUN->ALARM raises it).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alarm       <= 1'b0;
            alarm_pulse <= 1'b0;
        end else begin
            alarm       <= clear ? 1'b0 : (alarm | ctrl.alarm_set);
            alarm_pulse <= ctrl.alarm_set;
        end
    end

    // Overflow rises together with total_count reaching all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   overflow <= 1'b0;
        else if (clear) overflow <= 1'b0;
        else if (ctrl.tot_inc && (&total_count[CNT_W-1:1])) overflow <= 1'b1;
    end

    sdm_sat_counter #(.W(CNT_W)) u_total (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (ctrl.tot_inc),
        .count   (total_count)
    );

    sdm_sat_counter #(.W(CNT_W)) u_win (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (ctrl.win_clr),
        .inc     (ctrl.win_inc),
        .count   (win_count)
    );

endmodule

// File: tb/tb_sdm_event_monitor.sv
// Bench for sdm_event_monitor: directed scenarios then random traffic, all
// checked every cycle against a behavioural model of the monitor rules.
module tb_sdm_event_monitor;

    localparam int CW   = 4;
    localparam int WW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int WMOD = 1 << WW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          det_in = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [CW-1:0] threshold = '0;
    logic [CW-1:0] total_count, win_count;
    logic          alarm, alarm_pulse, overflow, io_oeb;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: plain counts, window position and two mode flags.
    int m_total, m_win, m_pos;
    bit m_active, m_alarm, m_pulse, m_ovf;

    sdm_event_monitor #(.CNT_W(CW), .WIN_W(WW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .det_in      (det_in),
        .enable      (enable),
        .clear       (clear),
        .window_len  (window_len),
        .threshold   (threshold),
        .total_count (total_count),
        .win_count   (win_count),
        .alarm       (alarm),
        .alarm_pulse (alarm_pulse),
        .overflow    (overflow),
        .io_oeb      (io_oeb)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic m_reset();
        m_total = 0; m_win = 0; m_pos = 0;
        m_active = 0; m_alarm = 0; m_pulse = 0; m_ovf = 0;
    endtask

    task automatic m_bump();
        if (m_total < CMAX) m_total++;
        if (m_total == CMAX) m_ovf = 1;
    endtask

    // One clock edge of the monitor rules, given the inputs sampled at it.
    task automatic m_step(input bit d, input bit e, input bit c);
        int wl, th;
        wl = int'(window_len);
        th = int'(threshold);
        m_pulse = 0;
        if (c) begin
            m_total = 0; m_win = 0; m_pos = 0; m_alarm = 0; m_ovf = 0;
            m_active = e;
        end else if (m_alarm) begin
            if (e && d) m_bump();
        end else if (!m_active) begin
            m_active = e;
        end else if (!e) begin
            m_active = 0; m_win = 0; m_pos = 0;
        end else begin
            if (d) m_bump();
            if (th != 0 && m_win + int'(d) >= th) begin
                m_alarm = 1; m_pulse = 1;
                m_win = (m_win + int'(d) > CMAX) ? CMAX : m_win + int'(d);
            end else if (wl != 0 && m_pos == wl - 1) begin
                m_win = 0; m_pos = 0;
            end else begin
                m_win = (m_win + int'(d) > CMAX) ? CMAX : m_win + int'(d);
                m_pos = (m_pos + 1) % WMOD;
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".total"}, 32'(total_count), m_total);
        chk({tag, ".win"},   32'(win_count),   m_win);
        chk({tag, ".alarm"}, 32'(alarm),       32'(m_alarm));
        chk({tag, ".pulse"}, 32'(alarm_pulse), 32'(m_pulse));
        chk({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
        chk({tag, ".oeb"},   32'(io_oeb),      0);
    endtask

    task automatic cyc(input bit d, input bit e, input bit c, input string tag);
        det_in = d; enable = e; clear = c;
        @(posedge clock);
        #1;
        m_step(d, e, c);
        cmp_all(tag);
    endtask

    // Asynchronous reset while events are arriving; outputs must drop at once.
    task automatic pulse_reset(input string tag);
        det_in = 1'b1; enable = 1'b1;
        reset_n = 1'b0;
        #1;
        m_reset();
        cmp_all({tag, ".async"});
        @(posedge clock);
        #1;
        cmp_all({tag, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset with det_in high, checked before any clock edge.
        reset_n = 1'b0; det_in = 1'b1; enable = 1'b1;
        #2;
        m_reset();
        cmp_all("rst0");
        repeat (2) @(posedge clock);
        #1;
        cmp_all("rst1");
        reset_n = 1'b1;
        cyc(0, 0, 0, "idle");

        // Threshold 3 in a 20-cycle window, pulses at cycles 2, 8, 14.
        window_len = 8'd20; threshold = 4'd3;
        for (int i = 0; i <= 15; i++) begin
            cyc(i == 2 || i == 8 || i == 14, 1, 0, "thr");
            if (i == 14) begin
                chk("thr.alarm_on", 32'(alarm), 1);
                chk("thr.pulse_on", 32'(alarm_pulse), 1);
                chk("thr.win3", 32'(win_count), 3);
            end
            if (i == 15) begin
                chk("thr.pulse_off", 32'(alarm_pulse), 0);
                chk("thr.alarm_held", 32'(alarm), 1);
            end
        end

        // Clear colliding with an event while in ALARM.
        cyc(1, 1, 1, "clr");
        chk("clr.alarm", 32'(alarm), 0);
        chk("clr.total", 32'(total_count), 0);
        chk("clr.win", 32'(win_count), 0);
        cyc(1, 1, 0, "clr_run");
        chk("clr_run.win", 32'(win_count), 1);

        // Window expiry: 2 events in window 1, 1 in window 2, threshold 3.
        window_len = 8'd10; threshold = 4'd3;
        cyc(0, 1, 1, "exp_clr");
        for (int i = 0; i <= 14; i++) begin
            cyc(i == 2 || i == 5 || i == 12, 1, 0, "exp");
            if (i == 8) chk("exp.win2", 32'(win_count), 2);
            if (i == 9) chk("exp.win0", 32'(win_count), 0);
        end
        chk("exp.no_alarm", 32'(alarm), 0);
        chk("exp.win1", 32'(win_count), 1);

        // Event in the last window cycle still counts toward the threshold.
        threshold = 4'd2;
        cyc(0, 1, 1, "bnd_clr");
        for (int i = 0; i <= 12; i++) begin
            cyc(i == 5 || i == 9 || i == 11, 1, 0, "bnd");
            if (i == 8) chk("bnd.pre", 32'(alarm), 0);
            if (i == 9) begin
                chk("bnd.alarm", 32'(alarm), 1);
                chk("bnd.win2", 32'(win_count), 2);
            end
        end
        chk("bnd.frozen", 32'(win_count), 2);
        chk("bnd.total", 32'(total_count), 3);

        // enable low: ALARM holds, RUN drops to IDLE and clears the window.
        cyc(1, 0, 0, "dis_alarm");
        chk("dis_alarm.held", 32'(alarm), 1);
        cyc(0, 1, 1, "dis_clr");
        cyc(1, 1, 0, "dis_run");
        cyc(0, 0, 0, "dis_idle");
        chk("dis_idle.win", 32'(win_count), 0);
        cyc(1, 1, 0, "dis_wake");
        chk("dis_wake.total", 32'(total_count), 1);

        // Saturation with the alarm disabled.
        threshold = 4'd0; window_len = 8'd0;
        cyc(0, 1, 1, "sat_clr");
        repeat (20) cyc(1, 1, 0, "sat");
        chk("sat.total", 32'(total_count), CMAX);
        chk("sat.ovf", 32'(overflow), 1);
        chk("sat.alarm", 32'(alarm), 0);

        // Random traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                window_len = WW'($urandom_range(0, 12));
                threshold  = CW'($urandom_range(0, 6));
            end
            if (i == 300) pulse_reset("rnd_rst");
            cyc($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 92,
                $urandom_range(0, 99) < 3, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdm_event_monitor.md
SDM_EVENT_MONITOR -- requirements
Module: sdm_event_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the event counters.
REQ-002 SHALL have parameter WIN_W, default 16, width of the window timer and window length.
REQ-003 SHALL have port clock, input, 1, the single clock; all flops are rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port det_in, input, 1, the sequence-detector output; each high cycle counts as one detection event.
REQ-006 SHALL have port enable, input, 1, monitoring enable.
REQ-007 SHALL have port clear, input, 1, synchronous clear of the counts, alarm and overflow.
REQ-008 SHALL have port window_len, input, WIN_W, window length in cycles; 0 disables window expiry.
REQ-009 SHALL have port threshold, input, CNT_W, alarm threshold; 0 disables the alarm.
REQ-010 SHALL have port total_count, output, CNT_W, saturating count of all events since clear.
REQ-011 SHALL have port win_count, output, CNT_W, count of events in the current window.
REQ-012 SHALL have port alarm, output, 1, sticky alarm flag.
REQ-013 SHALL have port alarm_pulse, output, 1, one-cycle strobe when alarm sets.
REQ-014 SHALL have port overflow, output, 1, sticky flag set when total_count saturates.
REQ-015 SHALL have port io_oeb, output, 1, tied to constant 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and ALARM.
REQ-017 IDLE: counters and timer hold; enable=1 -> RUN next cycle.
REQ-018 RUN: window timer increments each cycle; at timer==window_len-1 (window_len!=0), timer and win_count -> 0 next cycle.
REQ-019 SHALL treat an event sampled in the last window cycle as belonging to the expiring window for the threshold check.
REQ-020 SHALL update counts one cycle after sampling: det_in high in cycle N is visible in the counts in cycle N+1.
REQ-021 In RUN with threshold!=0: if win_count+det_in >= threshold, alarm=1 and alarm_pulse=1 in N+1, and the FSM goes to ALARM.
REQ-022 ALARM: alarm held; win_count and timer frozen; total_count keeps counting while enable=1.
REQ-023 Clear in any state: counts, timer, alarm and overflow -> 0 next cycle; next state = enable ? RUN : IDLE; a same-cycle event is dropped.
REQ-024 enable=0 in RUN: -> IDLE; timer and win_count -> 0; total_count held.
REQ-025 enable=0 in ALARM: stays in ALARM until clear.
REQ-026 total_count SHALL saturate at all-ones and set overflow the same cycle.
REQ-027 win_count SHALL saturate at all-ones and never wrap.
REQ-028 alarm_pulse SHALL never be high for two consecutive cycles.
REQ-029 io_oeb SHALL be 0 at all times.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE and all outputs 0: total_count, win_count, alarm, alarm_pulse, overflow.
REQ-031 Reset deassertion mid-operation SHALL resume from IDLE with all counts 0; no event is counted in the reset-release cycle unless enable=1 was already sampled the cycle before.

Structure
REQ-032 The FSM state encoding (IDLE=2'b00, RUN=2'b01, ALARM=2'b10) and the default CNT_W/WIN_W SHALL live in shared package sdm_pkg.
REQ-033 The saturating counter SHALL be one sub-module, sdm_sat_counter, instantiated twice (total, window).

Verification
REQ-034 Reset: reset_n=0 with det_in=1 -> all outputs 0, state IDLE.
REQ-035 Threshold: window_len=20, threshold=3, enable=1, det_in pulses at cycles 2, 8, 14 -> alarm and alarm_pulse in cycle 15, win_count=3; alarm stays high.
REQ-036 Window expiry: window_len=10, threshold=3, two pulses in window 1 and one in window 2 -> no alarm; win_count returns to 0 at the window boundary.
REQ-037 Boundary event: window_len=10, threshold=2, pulses in cycle 5 and cycle 9 (the last window cycle) -> alarm set; win_count then frozen at 2.
REQ-038 Clear collision: clear=1 and det_in=1 in the same cycle while in ALARM -> next cycle alarm=0, total_count=0, win_count=0, state RUN.
REQ-039 Saturation: CNT_W=4, det_in held high for 20 cycles, threshold=0 -> total_count=15, overflow=1, alarm=0.
